// File: rtl/snn_pkg.sv
// Shared SNN datapath types: encoder FSM states, AER transmit phases and
// default geometry for the spike encoder and decoder.
package snn_pkg;

  localparam int N_DEFAULT         = 256;
  localparam int PIX_W_DEFAULT     = 8;
  localparam int MIN_LEVEL_DEFAULT = 1;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    REQ,
    ACK_LOW,
    DONE
  } enc_state_t;

  // Phases of the transmit side of a four-phase AER link.
  typedef enum logic [1:0] {
    AER_IDLE,
    AER_WAIT_ACK_LOW,
    AER_REQ
  } aer_phase_t;

endpackage

// File: rtl/aer_tx_handshake.sv
// Transmit side of a four-phase AER link.
// Handshake: send is a one-cycle request from the owner, and the address is
// captured on it. req rises only while ack is low. The address changes only
// while req is low. accepted pulses in the cycle req and ack are both high,
// and req drops on that edge. idle means no transfer is in flight and ack has
// returned low.
module aer_tx_handshake
  import snn_pkg::*;
#(
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         send,
  input  logic [M-1:0] send_addr,
  input  logic         ack,
  output logic         req,
  output logic [M-1:0] addr,
  output logic         accepted,
  output logic         idle
);

  aer_phase_t phase_q;
  aer_phase_t phase_d;

  // Phase register; reset drops req at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase_q <= AER_IDLE;
    else     phase_q <= phase_d;
  end

  // A send that finds ack still high, such as an orphaned ack left over
  // from a reset, is held until ack goes low.
  always_comb begin
    phase_d = phase_q;
    unique case (phase_q)
      AER_IDLE:         if (send) phase_d = ack ? AER_WAIT_ACK_LOW : AER_REQ;
      AER_WAIT_ACK_LOW: if (!ack) phase_d = AER_REQ;
      AER_REQ:          if (ack)  phase_d = AER_IDLE;
      default:          phase_d = AER_IDLE;
    endcase
  end

  // The address register loads only from the idle phase, so it is stable while req is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             addr <= '0;
    else if (phase_q == AER_IDLE && send) addr <= send_addr;
  end

  // Link outputs and status toward the owner.
  always_comb begin
    req      = (phase_q == AER_REQ);
    accepted = (phase_q == AER_REQ) && ack;
    idle     = (phase_q == AER_IDLE) && !ack;
  end

endmodule

// File: rtl/aer_spike_encoder.sv
// Rank-order spike encoder. It buffers one image and scans it from the
// highest intensity level down to MIN_LEVEL. Within each level it scans in
// ascending address order and emits one AER event for each pixel whose value
// equals the current level.
module aer_spike_encoder
  import snn_pkg::*;
#(
  parameter  int N         = N_DEFAULT,
  parameter  int PIX_W     = PIX_W_DEFAULT,
  parameter  int MIN_LEVEL = MIN_LEVEL_DEFAULT,
  localparam int M         = $clog2(N)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IMG_WE,
  input  logic [M-1:0]     IMG_WADDR,
  input  logic [PIX_W-1:0] IMG_WDATA,
  input  logic             START,
  input  logic             INFERENCE_DONE,
  output logic [M-1:0]     AERIN_ADDR,
  output logic             AERIN_REQ,
  input  logic             AERIN_ACK,
  output logic             BUSY,
  output logic             IMAGE_DONE,
  output logic [M:0]       EVENT_CNT,
  output enc_state_t       DBG_STATE
);

  localparam logic [PIX_W-1:0] LEVEL_MAX = '1;
  localparam logic [PIX_W-1:0] LEVEL_MIN = PIX_W'(MIN_LEVEL);
  localparam logic [M-1:0]     ADDR_LAST = M'(N - 1);

  logic [PIX_W-1:0] pix [N];

  enc_state_t       state_q;
  enc_state_t       state_d;
  logic [PIX_W-1:0] level_q;
  logic [PIX_W-1:0] next_level;
  logic [M-1:0]     scan_addr_q;
  logic [M-1:0]     next_addr;
  logic [M:0]       cnt_q;
  logic             stop_q;
  logic             match;
  logic             last_pos;
  logic             send;
  logic             hs_accepted;
  logic             hs_idle;

  // The pixel buffer has no reset. It accepts writes only while idle.
  always_ff @(posedge CLK) begin
    if (IMG_WE && state_q == IDLE) pix[IMG_WADDR] <= IMG_WDATA;
  end

  assign match    = (pix[scan_addr_q] == level_q);
  assign last_pos = (scan_addr_q == ADDR_LAST) && (level_q == LEVEL_MIN);
  assign send     = (state_q == SCAN) && match && !INFERENCE_DONE;

  // Scan position step: wrap the address and drop one level at the end of a row.
  always_comb begin
    if (scan_addr_q == ADDR_LAST) begin
      next_addr  = '0;
      next_level = level_q - PIX_W'(1);
    end else begin
      next_addr  = scan_addr_q + M'(1);
      next_level = level_q;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state. An early stop in SCAN wins over a match. In REQ and ACK_LOW
  // the stop waits for the current handshake to finish.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (START) state_d = SCAN;
      SCAN: begin
        if (INFERENCE_DONE) state_d = DONE;
        else if (match)     state_d = REQ;
        else if (last_pos)  state_d = DONE;
      end
      REQ:     if (hs_accepted) state_d = ACK_LOW;
      ACK_LOW: begin
        if (hs_idle) state_d = (stop_q || INFERENCE_DONE || last_pos) ? DONE : SCAN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Scan position, stop latch and event counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      level_q     <= LEVEL_MAX;
      scan_addr_q <= '0;
      stop_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (START) begin
            level_q     <= LEVEL_MAX;
            scan_addr_q <= '0;
            stop_q      <= 1'b0;
            cnt_q       <= '0;
          end
        end
        SCAN: begin
          if (!INFERENCE_DONE && !match && !last_pos) begin
            level_q     <= next_level;
            scan_addr_q <= next_addr;
          end
        end
        REQ: begin
          if (INFERENCE_DONE) stop_q <= 1'b1;
          if (hs_accepted)    cnt_q  <= cnt_q + (M+1)'(1);
        end
        ACK_LOW: begin
          if (INFERENCE_DONE) stop_q <= 1'b1;
          if (hs_idle && !last_pos) begin
            level_q     <= next_level;
            scan_addr_q <= next_addr;
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs, decoded from the registered state.
  always_comb begin
    BUSY       = (state_q != IDLE);
    IMAGE_DONE = (state_q == DONE);
    EVENT_CNT  = cnt_q;
    DBG_STATE  = state_q;
  end

  aer_tx_handshake #(.M(M)) u_tx (
    .clk       (CLK),
    .rst       (RST),
    .send      (send),
    .send_addr (scan_addr_q),
    .ack       (AERIN_ACK),
    .req       (AERIN_REQ),
    .addr      (AERIN_ADDR),
    .accepted  (hs_accepted),
    .idle      (hs_idle)
  );

endmodule

// File: tb/tb_aer_spike_encoder.sv
// Directed bench for aer_spike_encoder with a small image (N=16). An SNN-side
// responder acknowledges requests with programmable delays. A monitor records
// every emitted address and counts link protocol violations.
module tb_aer_spike_encoder;
  import snn_pkg::*;

  localparam int N           = 16;
  localparam int M           = 4;
  localparam int PIX_W       = 8;
  localparam int SCAN_BUDGET = 255 * N + 3;
  localparam int RUN_BUDGET  = 6000;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             img_we = 1'b0;
  logic [M-1:0]     img_waddr = '0;
  logic [PIX_W-1:0] img_wdata = '0;
  logic             start = 1'b0;
  logic             inference_done = 1'b0;
  logic [M-1:0]     aerin_addr;
  logic             aerin_req;
  logic             aerin_ack = 1'b0;
  logic             busy;
  logic             image_done;
  logic [M:0]       event_cnt;
  enc_state_t       dbg_state;

  int n_assert = 0;
  int n_fail   = 0;
  int ack_rise_dly = 2;
  int ack_fall_dly = 2;
  int viol = 0;
  logic [M-1:0] got_q[$];
  logic [M-1:0] exp_q[$];
  logic         req_prev = 1'b0;
  logic [M-1:0] held_addr = '0;

  aer_spike_encoder #(.N(N), .PIX_W(PIX_W), .MIN_LEVEL(1)) dut (
    .CLK            (clk),
    .RST            (rst),
    .IMG_WE         (img_we),
    .IMG_WADDR      (img_waddr),
    .IMG_WDATA      (img_wdata),
    .START          (start),
    .INFERENCE_DONE (inference_done),
    .AERIN_ADDR     (aerin_addr),
    .AERIN_REQ      (aerin_req),
    .AERIN_ACK      (aerin_ack),
    .BUSY           (busy),
    .IMAGE_DONE     (image_done),
    .EVENT_CNT      (event_cnt),
    .DBG_STATE      (dbg_state)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  // SNN-side responder: it raises ack after the rise delay and lowers ack after
  // the fall delay once req has dropped.
  always begin
    @(negedge clk);
    if (aerin_req && !aerin_ack) begin
      #(ack_rise_dly);
      aerin_ack = 1'b1;
      wait (!aerin_req);
      #(ack_fall_dly);
      aerin_ack = 1'b0;
    end
  end

  // Link monitor: it records each request address. It counts a violation when
  // req rises while ack is high or when the address moves while req is high.
  always @(negedge clk) begin
    if (aerin_req && !req_prev) begin
      got_q.push_back(aerin_addr);
      held_addr = aerin_addr;
      if (aerin_ack) viol++;
    end else if (aerin_req && aerin_addr !== held_addr) begin
      viol++;
    end
    req_prev = aerin_req;
  end

  // Comparison helper
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic write_pix(input int a, input int d);
    img_we    = 1'b1;
    img_waddr = M'(a);
    img_wdata = PIX_W'(d);
    @(negedge clk);
    img_we    = 1'b0;
  endtask

  task automatic start_enc();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int cyc;
    bit seen;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (image_done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 32'(image_done), 32'd0);
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_events(input string tag, input int target, input int budget);
    int cyc;
    cyc = 0;
    while (got_q.size() < target && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_events_seen"}, 32'(got_q.size() >= target), 32'd1);
  endtask

  // Scoreboard: compare the addresses emitted since base with exp_q
  task automatic chk_events(input string tag, input int base);
    logic [31:0] g;
    chk({tag, "_event_count"}, 32'(got_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (base + i < got_q.size()) ? 32'(got_q[base + i]) : 32'hFFFF_FFFF;
      chk($sformatf("%s_ev%0d", tag, i), g, 32'(exp_q[i]));
    end
  endtask

  initial begin
    int base;
    int vbase;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req",   32'(aerin_req),  32'd0);
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_done",  32'(image_done), 32'd0);
    chk("rst_cnt",   32'(event_cnt),  32'd0);
    chk("rst_addr",  32'(aerin_addr), 32'd0);
    chk("rst_state", 32'(dbg_state),  32'(IDLE));
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) write_pix(i, 0);

    // Rank order: two pixels at 200 go in address order, then one pixel at 50
    write_pix(3, 200);
    write_pix(10, 200);
    write_pix(7, 50);
    base = got_q.size();
    start_enc();
    chk("t1_busy_rise", 32'(busy), 32'd1);
    wait_done("t1", RUN_BUDGET);
    exp_q = '{4'd3, 4'd10, 4'd7};
    chk_events("t1", base);
    chk("t1_cnt", 32'(event_cnt), 32'd3);
    chk("t1_addr_hold", 32'(aerin_addr), 32'd7);
    chk("t1_state", 32'(dbg_state), 32'(IDLE));

    // All-zero image: no events, finishes within the full scan time
    write_pix(3, 0);
    write_pix(10, 0);
    write_pix(7, 0);
    base = got_q.size();
    start_enc();
    wait_done("t2", SCAN_BUDGET);
    exp_q = {};
    chk_events("t2", base);
    chk("t2_cnt", 32'(event_cnt), 32'd0);

    // Early stop while the second event waits for ack
    write_pix(0, 255);
    write_pix(1, 254);
    write_pix(2, 253);
    ack_rise_dly = 22;
    ack_fall_dly = 2;
    base = got_q.size();
    start_enc();
    wait_events("t3", base + 2, 2000);
    inference_done = 1'b1;
    @(negedge clk);
    inference_done = 1'b0;
    wait_done("t3", RUN_BUDGET);
    exp_q = '{4'd0, 4'd1};
    chk_events("t3", base);
    chk("t3_cnt", 32'(event_cnt), 32'd2);

    // Slow ack fall on every event, including back-to-back matches
    write_pix(0, 0);
    write_pix(1, 0);
    write_pix(2, 0);
    write_pix(3, 200);
    write_pix(4, 200);
    write_pix(10, 200);
    ack_rise_dly = 2;
    ack_fall_dly = 32;
    base  = got_q.size();
    vbase = viol;
    start_enc();
    wait_done("t4", RUN_BUDGET);
    exp_q = '{4'd3, 4'd4, 4'd10};
    chk_events("t4", base);
    chk("t4_cnt", 32'(event_cnt), 32'd3);
    chk("t4_protocol", 32'(viol - vbase), 32'd0);

    // Writes while busy are ignored and take effect once idle
    write_pix(3, 0);
    write_pix(4, 0);
    write_pix(10, 0);
    write_pix(9, 100);
    ack_fall_dly = 2;
    base = got_q.size();
    start_enc();
    write_pix(5, 255);
    wait_done("t5a", RUN_BUDGET);
    exp_q = '{4'd9};
    chk_events("t5a", base);
    chk("t5a_cnt", 32'(event_cnt), 32'd1);
    write_pix(5, 255);
    base = got_q.size();
    start_enc();
    wait_done("t5b", RUN_BUDGET);
    exp_q = '{4'd5, 4'd9};
    chk_events("t5b", base);
    chk("t5b_cnt", 32'(event_cnt), 32'd2);

    // Reset during a handshake, then restart while an orphaned ack is high
    write_pix(5, 0);
    write_pix(9, 0);
    write_pix(0, 255);
    write_pix(1, 255);
    ack_rise_dly = 22;
    ack_fall_dly = 302;
    base = got_q.size();
    start_enc();
    wait_events("t6", base + 2, 2000);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_req",   32'(aerin_req),  32'd0);
    chk("t6_rst_busy",  32'(busy),       32'd0);
    chk("t6_rst_done",  32'(image_done), 32'd0);
    chk("t6_rst_cnt",   32'(event_cnt),  32'd0);
    chk("t6_rst_state", 32'(dbg_state),  32'(IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_idle_after_rst", 32'(busy), 32'd0);
    base  = got_q.size();
    vbase = viol;
    start_enc();
    repeat (3) @(negedge clk);
    chk("t6_req_held_off", 32'(aerin_req), 32'd0);
    wait_done("t6", RUN_BUDGET);
    exp_q = '{4'd0, 4'd1};
    chk_events("t6", base);
    chk("t6_cnt", 32'(event_cnt), 32'd2);
    chk("t6_protocol", 32'(viol - vbase), 32'd0);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
